button_pulse_conditioner: RTL and testbench

Conditions a raw, asynchronous, bouncing push-button into a clean single-cycle increment strobe. It sits directly upstream of the N-bit counter and drives that counter's `a` (count-enable) input, so one physical press advances the count by exactly one. It also exports the debounced button level for LEDs or other consumers.

---
 rtl/button_cond_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/button_pulse_conditioner.sv | 109 ++++++++++
 tb/tb_button_pulse_conditioner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/button_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } btn_state_t;

  // Width that holds counts up to max(a, b) - 1; never less than one bit.
  function automatic int unsigned cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : int'($clog2(m));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounces a raw push-button into a one-cycle count strobe plus a clean level.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module button_pulse_conditioner
  import button_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned BTN_ACTIVE_LOW  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  localparam int unsigned CW = cnt_width(int'(DEBOUNCE_CYCLES), int'(REPEAT_CYCLES));
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  btn_state_t    state;
  logic [CW-1:0] db_cnt;
  logic          btn_pol;
  logic          s;

  assign btn_pol = (BTN_ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_pol),
    .q   (s)
  );

`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rep_cnt;
`endif

  // Debounce FSM; pulse defaults low so every strobe lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      db_cnt <= '0;
      pulse  <= 1'b0;
      level  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          level <= 1'b0;
          if (s) begin
            state  <= PRESS_CHK;
            db_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state <= PRESSED;
            pulse <= 1'b1;
            level <= 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state  <= RELEASE_CHK;
            db_cnt <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == RP_LAST) begin
            pulse   <= 1'b1;
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + CW'(1);
`endif
          end
        end
        RELEASE_CHK: begin
`ifdef AUTO_REPEAT_EN
          rep_cnt <= '0;
`endif
          // A glitch back to pressed is a release bounce, not a new press.
          if (s) begin
            state <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
            level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
module tb_button_pulse_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RP = 8;
`ifdef AUTO_REPEAT_EN
  localparam int EXP_REP = 3;
`else
  localparam int EXP_REP = 0;
`endif

  typedef struct {
    logic btn;
    logic p;
    logic l;
  } vec_t;

  logic clk = 1'b0;
  logic rst, btn, btn_inv;
  logic pulse, level, pulse_inv, level_inv;
  logic [1:0] cnt_model;

  int cyc = 0;
  int pq[$];
  int bad = 0;
  logic prev_p = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t tbl[16];

  always #10 clk = ~clk;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP), .BTN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn), .pulse(pulse), .level(level)
  );

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP), .BTN_ACTIVE_LOW(1)
  ) dut_inv (
    .clk(clk), .rst(rst), .btn_in(btn_inv), .pulse(pulse_inv), .level(level_inv)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 2-bit counter fed by pulse, reset to 2'b10.
  always @(posedge clk) begin
    if (!rst) cnt_model <= 2'b10;
    else if (pulse) cnt_model <= cnt_model + 2'd1;
  end

  // Log the edge number of every pulse; flag back-to-back or in-reset strobes.
  always @(negedge clk) begin
    if (pulse === 1'b1) begin
      pq.push_back(cyc);
      if (prev_p === 1'b1 || rst === 1'b0) bad = bad + 1;
    end
    prev_p = pulse;
  end

  task automatic tick(input logic b, input logic r);
    btn = b;
    btn_inv = ~b;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int count_in(input int lo, input int hi);
    int n = 0;
    foreach (pq[i]) if (pq[i] >= lo && pq[i] <= hi) n++;
    return n;
  endfunction

  function automatic int first_in(input int lo, input int hi);
    foreach (pq[i]) if (pq[i] >= lo && pq[i] <= hi) return pq[i];
    return -1;
  endfunction

  initial begin
    int base, j0, f, p, k;

    // Clean press: pressed from index 3, strobe 6 edges later at index 9.
    for (int i = 0; i < 16; i++) begin
      tbl[i].btn = (i >= 3);
      tbl[i].p   = (i == 9);
      tbl[i].l   = (i >= 9);
    end

    rst = 1'b0; btn = 1'b0; btn_inv = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_pulse_inv", int'(pulse_inv), 0);
    chk("reset_level_inv", int'(level_inv), 0);

    base = cyc;
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].btn, 1'b1);
      chk($sformatf("clean_pulse[%0d]", i), int'(pulse), int'(tbl[i].p));
      chk($sformatf("clean_level[%0d]", i), int'(level), int'(tbl[i].l));
      chk($sformatf("inv_pulse[%0d]", i), int'(pulse_inv), int'(tbl[i].p));
      chk($sformatf("inv_level[%0d]", i), int'(level_inv), int'(tbl[i].l));
    end
    chk("counter_after_press", int'(cnt_model), 3);

    // Keep holding; repeats only appear when auto-repeat is built.
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1);
    chk("repeat_count", count_in(base + 11, base + 40), EXP_REP);

    // Release bounce: low 2, high 1, then low for good.
    j0 = cyc + 1;
    f = j0 + 3;
    tick(1'b0, 1'b1); chk("rel_bounce_level0", int'(level), 1);
    tick(1'b0, 1'b1); chk("rel_bounce_level1", int'(level), 1);
    tick(1'b1, 1'b1); chk("rel_bounce_level2", int'(level), 1);
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("rel_level_e%0d", cyc - j0), int'(level), (cyc < f + 6) ? 1 : 0);
    end
    chk("rel_bounce_pulses", count_in(j0, cyc), 0);

    // Press bounce: 1,0,1,0 then hold; one pulse 6 edges after the final rise.
    p = cyc + 1;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
    chk("press_bounce_count", count_in(p, cyc), 1);
    chk("press_bounce_edge", first_in(p, cyc), p + 10);
    chk("press_bounce_level", int'(level), 1);

    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    chk("released_level", int'(level), 0);

    // Reset pulse while in PRESS_CHK with the button still held.
    k = cyc + 1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    chk("midreset_pulse", int'(pulse), 0);
    chk("midreset_level", int'(level), 0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    chk("midreset_count", count_in(k, cyc), 1);
    chk("midreset_edge", first_in(k, cyc), k + 10);
    chk("midreset_level_after", int'(level), 1);

    chk("no_double_or_reset_pulse", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
